// File: rtl/regfile_combo_ctrl.sv
// Purpose: sequencer for the RegFiles XOR-accumulate file. Loads WR basis words, then emits N random combinations.
// Latency: a mask accepted in cycle t gives out_valid at t+2, so each output takes at least 3 cycles.
// Backpressure: basis, mask and output streams are valid/ready, and the output is held stable while out_ready_i is low.
// Ports: clk_i/rst_i (sync, active-high); start_i/load_en_i/busy_o/done_o job control;
//        basis_* load stream (M bits); rand_* mask stream (WR bits, MSB selects entry 0);
//        rf_* RegFiles controls and registered data_out; out_* combination stream with out_last_o.
module regfile_combo_ctrl #(
  parameter int N  = 4,
  parameter int M  = 8,
  parameter int WR = 6,
  localparam int AW = (WR > 1) ? $clog2(WR) : 1,
  localparam int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          load_en_i,
  output logic          busy_o,
  output logic          done_o,
  input  logic          basis_valid_i,
  output logic          basis_ready_o,
  input  logic [M-1:0]  basis_data_i,
  input  logic          rand_valid_i,
  output logic          rand_ready_o,
  input  logic [WR-1:0] rand_data_i,
  output logic          rf_rw_o,
  output logic [WR:0]   rf_ctrl_w_o,
  output logic [AW-1:0] rf_addr_o,
  output logic [M-1:0]  rf_data_in_o,
  input  logic [M-1:0]  rf_data_out_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [M-1:0]  out_data_o,
  output logic          out_last_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GEN_REQ,
    S_GEN_WAIT,
    S_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ld_cnt_q, ld_cnt_d;
  logic [GW-1:0] gen_cnt_q, gen_cnt_d;
  logic [M-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= '0;
      gen_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      gen_cnt_q   <= gen_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    gen_cnt_d     = gen_cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    done_d        = 1'b0;
    basis_ready_o = 1'b0;
    rand_ready_o  = 1'b0;
    rf_rw_o       = 1'b0;
    rf_ctrl_w_o   = '0;
    rf_addr_o     = ld_cnt_q;
    rf_data_in_o  = '0;

    case (state_q)
      S_IDLE: begin
        ld_cnt_d  = '0;
        gen_cnt_d = '0;
        if (start_i) begin
          state_d = load_en_i ? S_LOAD : S_GEN_REQ;
        end
      end
      S_LOAD: begin
        basis_ready_o = 1'b1;
        if (basis_valid_i) begin
          // The write lands on the same edge as the handshake.
          rf_rw_o      = 1'b1;
          rf_data_in_o = basis_data_i;
          if (ld_cnt_q == AW'(WR - 1)) begin
            state_d = S_GEN_REQ;
          end else begin
            ld_cnt_d = ld_cnt_q + AW'(1);
          end
        end
      end
      S_GEN_REQ: begin
        rand_ready_o = 1'b1;
        // A zero mask is swallowed and a fresh one is requested, so an all-zero combination never goes out.
        if (rand_valid_i && (rand_data_i != '0)) begin
          rf_ctrl_w_o = {1'b1, rand_data_i};
          state_d     = S_GEN_WAIT;
        end
      end
      S_GEN_WAIT: begin
        // RegFiles data_out is registered, so the XOR result is visible one cycle after the request.
        out_data_d  = rf_data_out_i;
        out_valid_d = 1'b1;
        out_last_d  = (gen_cnt_q == GW'(N - 1));
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            gen_cnt_d = gen_cnt_q + GW'(1);
            state_d   = S_GEN_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reset aborts at once: no write, XOR request or stream handshake in the reset cycle itself.
    if (rst_i) begin
      basis_ready_o = 1'b0;
      rand_ready_o  = 1'b0;
      rf_rw_o       = 1'b0;
      rf_ctrl_w_o   = '0;
      rf_data_in_o  = '0;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_regfile_combo_ctrl.sv
// Bench for regfile_combo_ctrl with a behavioural RegFiles and a golden XOR model of the stored basis.
module tb_regfile_combo_ctrl;
  localparam int N  = 4;
  localparam int M  = 8;
  localparam int WR = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, start, load_en, busy, done;
  logic          basis_valid, basis_ready, rand_valid, rand_ready;
  logic [M-1:0]  basis_data, rf_data_in, out_data;
  logic [M-1:0]  rf_data_out = '0;
  logic [WR-1:0] rand_data;
  logic          rf_rw, out_valid, out_ready, out_last;
  logic [WR:0]   rf_ctrl_w;
  logic [AW-1:0] rf_addr;

  always #5 clk = ~clk;

  regfile_combo_ctrl #(.N(N), .M(M), .WR(WR)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .load_en_i(load_en),
    .busy_o(busy), .done_o(done),
    .basis_valid_i(basis_valid), .basis_ready_o(basis_ready), .basis_data_i(basis_data),
    .rand_valid_i(rand_valid), .rand_ready_o(rand_ready), .rand_data_i(rand_data),
    .rf_rw_o(rf_rw), .rf_ctrl_w_o(rf_ctrl_w), .rf_addr_o(rf_addr),
    .rf_data_in_o(rf_data_in), .rf_data_out_i(rf_data_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last)
  );

  // Behavioural RegFiles: contents survive rst, data_out is registered.
  logic [M-1:0] rf_mem [WR];
  logic [M-1:0] rf_acc;
  always @(posedge clk) begin
    if (rf_rw && int'(rf_addr) < WR) rf_mem[rf_addr] <= rf_data_in;
    if (rf_ctrl_w[WR]) begin
      rf_acc = '0;
      for (int i = 0; i < WR; i++) if (rf_ctrl_w[WR-1-i]) rf_acc = rf_acc ^ rf_mem[i];
      rf_data_out <= rf_acc;
    end
  end

  int n_checks = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [M-1:0]  golden [WR];
  logic [M-1:0]  basis_q [$];
  logic [WR-1:0] mask_q [$];
  logic [M-1:0]  exp_q [$];
  logic [M-1:0]  out_log [$];
  bit stall_en = 0, rnd_ordy = 0, mon_en = 0, hs_armed = 0;
  int hold_left = 0, wr_idx = 0, rhs_cnt = 0, br_cnt = 0, out_cnt = 0, job_out = 0, hs_age = 0;
  logic prev_ov = 0, prev_ordy = 0, prev_ol = 0, prev_done = 0;
  logic [M-1:0] prev_od = '0;

  // Expected combination: every set mask bit b selects basis entry WR-1-b.
  function automatic logic [M-1:0] comb(input logic [WR-1:0] mk);
    logic [M-1:0] r;
    r = '0;
    for (int b = 0; b < WR; b++) if (mk[b]) r = r ^ golden[WR-1-b];
    return r;
  endfunction

  initial begin
    bit hs;
    basis_valid = 0; basis_data = '0;
    forever begin
      @(negedge clk); hs = basis_valid && basis_ready;
      @(posedge clk); #1;
      if (hs && basis_q.size() > 0) void'(basis_q.pop_front());
      if (basis_q.size() > 0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
        basis_valid = 1; basis_data = basis_q[0];
      end else begin
        basis_valid = 0; basis_data = M'($urandom);
      end
    end
  end

  initial begin
    bit hs;
    rand_valid = 0; rand_data = '0;
    forever begin
      @(negedge clk); hs = rand_valid && rand_ready;
      @(posedge clk); #1;
      if (hs && mask_q.size() > 0) void'(mask_q.pop_front());
      if (mask_q.size() > 0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
        rand_valid = 1; rand_data = mask_q[0];
      end else begin
        rand_valid = 0; rand_data = WR'($urandom);
      end
    end
  end

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (out_valid && hold_left > 0) begin
        out_ready = 0; hold_left--;
      end else if (rnd_ordy) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rf_rw || (basis_valid && basis_ready)) check("wr_on_hs", rf_rw, basis_valid && basis_ready);
      if (rf_rw) begin
        check("wr_addr", rf_addr, wr_idx);
        if (wr_idx < WR) check("wr_data", rf_data_in, golden[wr_idx]);
        else check("wr_extra", wr_idx, WR - 1);
        check("rw_with_xor", rf_ctrl_w[WR], 0);
        wr_idx++;
      end
      if (basis_ready) br_cnt++;
      if (hs_armed) hs_age++;
      if (out_valid && !prev_ov) begin
        check("out_latency", hs_armed ? hs_age : -1, 2);
        hs_armed = 0;
      end
      if (rand_valid && rand_ready) begin
        rhs_cnt++;
        check("xor_req", rf_ctrl_w[WR], rand_data != 0);
        if (rand_data != 0) begin
          check("xor_mask", rf_ctrl_w[WR-1:0], rand_data);
          exp_q.push_back(comb(rand_data));
          hs_armed = 1; hs_age = 0;
        end
      end else if (rf_ctrl_w[WR]) check("xor_no_hs", rf_ctrl_w[WR], 0);
      if (out_valid) begin
        check("rr_during_out", rand_ready, 0);
        check("xor_during_out", rf_ctrl_w[WR], 0);
      end
      if (prev_ov && !prev_ordy) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_od);
        check("stall_last", out_last, prev_ol);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        out_log.push_back(out_data);
        check("exp_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
        check("out_last", out_last, job_out == N - 1);
        job_out++;
      end
      if (done) begin
        check("done_busy", busy, 0);
        check("done_single", prev_done, 0);
        check("done_exp_empty", exp_q.size(), 0);
      end
    end
    prev_ov = out_valid; prev_ordy = out_ready; prev_ol = out_last;
    prev_od = out_data; prev_done = done;
  end

  // One job: caller fills golden (if ld) and mask_q; returns in the done cycle.
  task automatic run_job(input bit ld, input int start_len);
    int nm, rb, bb, ob, t;
    nm = mask_q.size(); rb = rhs_cnt; bb = br_cnt; ob = out_cnt;
    job_out = 0; wr_idx = 0; out_log.delete();
    if (ld) for (int e = 0; e < WR; e++) basis_q.push_back(golden[e]);
    @(posedge clk); #1; start = 1; load_en = ld;
    repeat (start_len) begin @(posedge clk); #1; end
    start = 0; load_en = 0;
    @(negedge clk); check("busy_after_start", busy, 1);
    t = 0;
    while (!done && t < 3000) begin @(negedge clk); t++; end
    check("job_done_in_time", t < 3000, 1);
    check("job_outputs", out_cnt - ob, N);
    check("job_rand_hs", rhs_cnt - rb, nm);
    if (ld) check("job_writes", wr_idx, WR);
    else check("job_no_basis_ready", br_cnt - bb, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);        check({tag, "_done"}, done, 0);
    check({tag, "_ovalid"}, out_valid, 0); check({tag, "_olast"}, out_last, 0);
    check({tag, "_odata"}, out_data, 0);   check({tag, "_bready"}, basis_ready, 0);
    check({tag, "_rready"}, rand_ready, 0); check({tag, "_rw"}, rf_rw, 0);
    check({tag, "_ctrl"}, rf_ctrl_w, 0);   check({tag, "_addr"}, rf_addr, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M-1:0] exp_a [4];
    int t, oc, nz;
    logic [M-1:0] g0;
    exp_a = '{8'h01, 8'h20, 8'h3F, 8'h15};
    rst = 1; start = 0; load_en = 0;
    repeat (3) @(posedge clk);
    #1; check_all_zero("reset");
    rst = 0; mon_en = 1;
    repeat (2) @(posedge clk);

    // Basic load then generate.
    for (int e = 0; e < WR; e++) golden[e] = M'(1 << e);
    mask_q.push_back(6'b100000); mask_q.push_back(6'b000001);
    mask_q.push_back(6'b111111); mask_q.push_back(6'b101010);
    run_job(1, 1);
    for (int i = 0; i < 4; i++) check("basic_out", (out_log.size() > i) ? out_log[i] : 8'hxx, exp_a[i]);

    // Zero-mask reject, reusing the basis.
    mask_q.push_back(6'b000000); mask_q.push_back(6'b000000); mask_q.push_back(6'b010000);
    mask_q.push_back(6'b000011); mask_q.push_back(6'b111111); mask_q.push_back(6'b000001);
    run_job(0, 1);
    check("zero_mask_first", (out_log.size() > 0) ? out_log[0] : 8'hxx, 8'h02);

    // Reuse basis with a 10-cycle output stall on the first combination.
    hold_left = 10;
    mask_q.push_back(6'b000011); mask_q.push_back(6'b100001);
    mask_q.push_back(6'b010100); mask_q.push_back(6'b001000);
    run_job(0, 1);
    check("reuse_first", (out_log.size() > 0) ? out_log[0] : 8'hxx, 8'h30);
    check("stall_consumed", hold_left, 0);

    // Random basis, random stream stalls, random masks; start held while busy is ignored.
    stall_en = 1; rnd_ordy = 1;
    for (int j = 0; j < 5; j++) begin
      if (j != 4) for (int e = 0; e < WR; e++) golden[e] = M'($urandom);
      nz = 0;
      while (nz < N) begin
        if ($urandom_range(0, 3) == 0) mask_q.push_back('0);
        else begin mask_q.push_back(WR'($urandom_range(1, (1 << WR) - 1))); nz++; end
      end
      run_job(j != 4, 3);
    end
    stall_en = 0; rnd_ordy = 0;

    // Reset in GEN_WAIT aborts; the basis survives for the next job.
    oc = out_cnt;
    mask_q.push_back(6'b000111); mask_q.push_back(6'b000110);
    mask_q.push_back(6'b000101); mask_q.push_back(6'b000100);
    @(posedge clk); #1; start = 1; load_en = 0;
    @(posedge clk); #1; start = 0;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(rand_valid && rand_ready && rand_data != 0) && t < 100);
    check("abort_saw_mask", t < 100, 1);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1;
    check_all_zero("abort");
    rst = 0;
    mask_q.delete(); exp_q.delete(); hs_armed = 0;
    repeat (5) @(negedge clk);
    check("abort_no_output", out_cnt, oc);
    g0 = golden[0];
    mask_q.push_back(6'b100000); mask_q.push_back(6'b010000);
    mask_q.push_back(6'b001000); mask_q.push_back(6'b000100);
    run_job(0, 1);
    check("post_abort_first", (out_log.size() > 0) ? out_log[0] : 8'hxx, g0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
